// File: rtl/reg_bus_arb_pkg.sv
// rtl/reg_bus_arb_pkg.sv - shared types and constants for the register bus arbiter
// Contents: FSM state enum, master index constants, last_grant reset value,
// latency counter width.
package reg_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Pretending m1 went last lets m0 win the first tie after reset.
  localparam logic LAST_GRANT_RST = M1;

  localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
// Ports:
//   req0, req1  in   request lines of master 0 / master 1
//   last_grant  in   index of the master served most recently
//   grant       out  picked master index (meaningful when valid)
//   valid       out  at least one request is present
module rr_arb2
  import reg_bus_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    grant = M0;
    if (req0 && req1) begin
      // Tie: hand the bus to whichever master did not go last.
      grant = (last_grant == M0) ? M1 : M0;
    end else if (req1) begin
      grant = M1;
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - two-master round-robin arbiter for the register slave port
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   m0_req/m0_wr/m0_addr/m0_wrdata master 0 request (held until m0_ack)
//   m0_ack, m0_rddata              master 0 one-cycle ack, read data (held)
//   m1_*                           same for master 1
//   slave_addr/slave_wr/slave_rd/slave_wrdata  registered slave strobes
//   slave_rddata                   slave read data, valid RD_LAT cycles after slave_rd
module reg_bus_arbiter
  import reg_bus_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wrdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rddata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wrdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rddata,
  output logic [ADDR_W-1:0] slave_addr,
  output logic              slave_wr,
  output logic              slave_rd,
  output logic [DATA_W-1:0] slave_wrdata,
  input  logic [DATA_W-1:0] slave_rddata
);

  localparam logic [LAT_CNT_W-1:0] LAT_RELOAD = LAT_CNT_W'(RD_LAT - 1);

  arb_state_t            state, state_nxt;
  logic                  grant_idx, grant_nxt;
  logic                  last_grant, last_grant_nxt;
  logic                  wr_q, wr_nxt;
  logic [LAT_CNT_W-1:0]  lat_cnt, lat_nxt;
  logic [ADDR_W-1:0]     addr_nxt;
  logic [DATA_W-1:0]     wrdata_nxt;
  logic                  slave_wr_nxt, slave_rd_nxt;
  logic                  m0_ack_nxt, m1_ack_nxt;
  logic [DATA_W-1:0]     m0_rddata_nxt, m1_rddata_nxt;
  logic                  pick_grant, pick_valid;

  rr_arb2 u_rr_arb2 (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_idx    <= M0;
      last_grant   <= LAST_GRANT_RST;
      wr_q         <= 1'b0;
      lat_cnt      <= '0;
      slave_addr   <= '0;
      slave_wrdata <= '0;
      slave_wr     <= 1'b0;
      slave_rd     <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rddata    <= '0;
      m1_rddata    <= '0;
    end else begin
      state        <= state_nxt;
      grant_idx    <= grant_nxt;
      last_grant   <= last_grant_nxt;
      wr_q         <= wr_nxt;
      lat_cnt      <= lat_nxt;
      slave_addr   <= addr_nxt;
      slave_wrdata <= wrdata_nxt;
      slave_wr     <= slave_wr_nxt;
      slave_rd     <= slave_rd_nxt;
      m0_ack       <= m0_ack_nxt;
      m1_ack       <= m1_ack_nxt;
      m0_rddata    <= m0_rddata_nxt;
      m1_rddata    <= m1_rddata_nxt;
    end
  end

  // Every output is a register; this block computes the value each one
  // takes in the next cycle. Strobes and acks default low so they pulse.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_idx;
    last_grant_nxt = last_grant;
    wr_nxt         = wr_q;
    lat_nxt        = lat_cnt;
    addr_nxt       = slave_addr;
    wrdata_nxt     = slave_wrdata;
    slave_wr_nxt   = 1'b0;
    slave_rd_nxt   = 1'b0;
    m0_ack_nxt     = 1'b0;
    m1_ack_nxt     = 1'b0;
    m0_rddata_nxt  = m0_rddata;
    m1_rddata_nxt  = m1_rddata;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt = pick_grant;
          if (pick_grant == M0) begin
            addr_nxt   = m0_addr;
            wrdata_nxt = m0_wrdata;
            wr_nxt     = m0_wr;
          end else begin
            addr_nxt   = m1_addr;
            wrdata_nxt = m1_wrdata;
            wr_nxt     = m1_wr;
          end
          // Strobe is registered here so it is high exactly during ISSUE.
          slave_wr_nxt = wr_nxt;
          slave_rd_nxt = !wr_nxt;
          state_nxt    = ISSUE;
        end
      end

      ISSUE: begin
        if (wr_q) begin
          m0_ack_nxt = (grant_idx == M0);
          m1_ack_nxt = (grant_idx == M1);
          state_nxt  = DONE;
        end else begin
          lat_nxt   = LAT_RELOAD;
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (lat_cnt == '0) begin
          // slave_rddata is valid in this cycle only; earlier values are ignored.
          if (grant_idx == M0) begin
            m0_rddata_nxt = slave_rddata;
            m0_ack_nxt    = 1'b1;
          end else begin
            m1_rddata_nxt = slave_rddata;
            m1_ack_nxt    = 1'b1;
          end
          state_nxt = DONE;
        end else begin
          lat_nxt = lat_cnt - 1'b1;
        end
      end

      DONE: begin
        last_grant_nxt = grant_idx;
        state_nxt      = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
